pc_next_ctrl: RTL and testbench

- Next-PC sequencer for the 5-stage MIPS pipeline; feeds pc_next of the PC register every cycle.
- Arbitrates between sequential fetch, ID-stage redirects (branch, jump, jump-register), ERET, and exceptions.
- The PC register has no enable, so fetch stalls are implemented by driving pc_next = pc.
- Holds a redirect that arrives during a stall and applies it when the stall releases; sequences the post-exception flush.

---
 rtl/pc_next_ctrl_pkg.sv | 50 +++++
 rtl/pc_redirect_latch.sv | 30 +++
 rtl/pc_next_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pc_next_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_next_ctrl_pkg.sv
// rtl/pc_next_ctrl_pkg.sv - shared state encodings, pc_src codes and branch-class select for pc_next_ctrl
`ifndef DEFAULT_PC
`define DEFAULT_PC 32'hBFC0_0000
`endif

package pc_next_ctrl_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [2:0] SRC_SEQ  = 3'd0;
    localparam logic [2:0] SRC_HOLD = 3'd1;
    localparam logic [2:0] SRC_BR   = 3'd2;
    localparam logic [2:0] SRC_JMP  = 3'd3;
    localparam logic [2:0] SRC_JR   = 3'd4;
    localparam logic [2:0] SRC_ERET = 3'd5;
    localparam logic [2:0] SRC_EXC  = 3'd6;
    localparam logic [2:0] SRC_PEND = 3'd7;

    typedef struct packed {
        logic        valid;
        logic [31:0] target;
        logic [2:0]  src;
    } redir_t;

    // ID-stage redirects: jr beats jmp beats br_taken; losers are dropped.
    function automatic redir_t pick_branch(
        input logic        jr,
        input logic [31:0] jr_target,
        input logic        jmp,
        input logic [31:0] jmp_target,
        input logic        br_taken,
        input logic [31:0] br_target
    );
        redir_t r;
        r.valid  = jr | jmp | br_taken;
        r.target = br_target;
        r.src    = SRC_BR;
        if (jr) begin
            r.target = jr_target;
            r.src    = SRC_JR;
        end else if (jmp) begin
            r.target = jmp_target;
            r.src    = SRC_JMP;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// rtl/pc_redirect_latch.sv - holds one redirect target that arrived while fetch was stalled
module pc_redirect_latch (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] target_i,
    output logic        valid_o,
    output logic [31:0] target_o
);

    logic        valid_q;
    logic [31:0] target_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            target_q <= 32'h0;
        end else if (clear_i) begin
            valid_q  <= 1'b0;
        end else if (load_i) begin
            valid_q  <= 1'b1;
            target_q <= target_i;
        end
    end

    assign valid_o  = valid_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_next_ctrl.sv
// rtl/pc_next_ctrl.sv - next-PC sequencer; PC_ALIGN_CHECK_EN adds misaligned-target trapping and bad_vaddr
module pc_next_ctrl
    import pc_next_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int          DELAY_SLOT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] pc_4,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        exc,
    output logic [31:0] pc_next,
    output logic [2:0]  pc_src,
    output logic        if_flush,
    output logic        redir_pending
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic [31:0] bad_vaddr
`endif
);

    logic [1:0]  state_q, state_d;
    redir_t      br_sel;
    logic        pend_load, pend_clear, pend_valid;
    logic [31:0] pend_target;
    logic        iss_valid, iss_to_flush;
    logic [31:0] iss_target;
    logic [2:0]  iss_src;
`ifdef PC_ALIGN_CHECK_EN
    logic        fault;
    logic [31:0] bad_vaddr_q;
`endif

    pc_redirect_latch u_latch (
        .clk      (clk),
        .rst      (rst),
        .load_i   (pend_load),
        .clear_i  (pend_clear),
        .target_i (br_sel.target),
        .valid_o  (pend_valid),
        .target_o (pend_target)
    );

    always_comb begin
        br_sel       = pick_branch(jr, jr_target, jmp, jmp_target, br_taken, br_target);
        state_d      = ST_RUN;
        pc_next      = pc_4;
        pc_src       = SRC_SEQ;
        if_flush     = 1'b0;
        pend_load    = 1'b0;
        pend_clear   = 1'b0;
        iss_valid    = 1'b0;
        iss_to_flush = 1'b0;
        iss_target   = pc_4;
        iss_src      = SRC_SEQ;
`ifdef PC_ALIGN_CHECK_EN
        fault        = 1'b0;
`endif
        if (rst) begin
            pc_next    = `DEFAULT_PC;
            if_flush   = 1'b1;
            pend_clear = 1'b1;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    // Branch-class inputs here come from squashed instructions.
                    if_flush = 1'b1;
                    if (exc) begin
                        pc_next = EXC_VECTOR;
                        pc_src  = SRC_EXC;
                        state_d = ST_FLUSH;
                    end else if (stall) begin
                        pc_next = pc;
                        pc_src  = SRC_HOLD;
                    end
                end
                default: begin
                    if (exc) begin
                        pc_next    = EXC_VECTOR;
                        pc_src     = SRC_EXC;
                        if_flush   = 1'b1;
                        state_d    = ST_FLUSH;
                        pend_clear = 1'b1;
                    end else if (eret) begin
                        iss_valid    = 1'b1;
                        iss_target   = epc;
                        iss_src      = SRC_ERET;
                        iss_to_flush = 1'b1;
                        pend_clear   = 1'b1;
                    end else if (state_q == ST_PEND) begin
                        if (stall) begin
                            pc_next = pc;
                            pc_src  = SRC_HOLD;
                            state_d = ST_PEND;
                        end else begin
                            iss_valid  = 1'b1;
                            iss_target = pend_target;
                            iss_src    = SRC_PEND;
                            pend_clear = 1'b1;
                        end
                    end else if (br_sel.valid) begin
                        if (stall) begin
                            pc_next   = pc;
                            pc_src    = SRC_HOLD;
                            pend_load = 1'b1;
                            state_d   = ST_PEND;
                        end else begin
                            iss_valid  = 1'b1;
                            iss_target = br_sel.target;
                            iss_src    = br_sel.src;
                        end
                    end else if (stall) begin
                        pc_next = pc;
                        pc_src  = SRC_HOLD;
                    end
                end
            endcase

            if (iss_valid) begin
                pc_next  = iss_target;
                pc_src   = iss_src;
                if_flush = iss_to_flush | (DELAY_SLOT == 0);
                if (iss_to_flush) state_d = ST_FLUSH;
`ifdef PC_ALIGN_CHECK_EN
                if (iss_target[1:0] != 2'b00) begin
                    pc_next  = EXC_VECTOR;
                    pc_src   = SRC_EXC;
                    if_flush = 1'b1;
                    state_d  = ST_FLUSH;
                    fault    = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    assign redir_pending = pend_valid & ~rst;

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)        bad_vaddr_q <= 32'h0;
        else if (fault) bad_vaddr_q <= iss_target;
    end

    assign bad_vaddr = bad_vaddr_q;
`endif

endmodule

// File: tb/tb_pc_next_ctrl.sv
// tb/tb_pc_next_ctrl.sv - directed and randomized self-checking bench for pc_next_ctrl
module tb_pc_next_ctrl;

    localparam logic [31:0] EXC = 32'hBFC0_0380;
    localparam int          DS  = 1;
`ifdef DEFAULT_PC
    localparam logic [31:0] DEF = `DEFAULT_PC;
`else
    localparam logic [31:0] DEF = 32'hBFC0_0000;
`endif
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, br_taken, jmp, jr, eret, exc;
    logic [31:0] pc, pc_4, br_target, jmp_target, jr_target, epc;
    logic [31:0] pc_next;
    logic [2:0]  pc_src;
    logic        if_flush, redir_pending;
`ifdef PC_ALIGN_CHECK_EN
    logic [31:0] bad_vaddr;
`endif

    int errors = 0;
    int checks = 0;

    bit          m_pending, m_flush, n_pending, n_flush;
    logic [31:0] m_tgt, m_bad, n_tgt, n_bad;
    logic [31:0] e_pc;
    logic [2:0]  e_src;
    logic        e_flush, e_pend;

    pc_next_ctrl #(.EXC_VECTOR(EXC), .DELAY_SLOT(DS)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_4(pc_4), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target),
        .jr(jr), .jr_target(jr_target),
        .eret(eret), .epc(epc), .exc(exc),
        .pc_next(pc_next), .pc_src(pc_src), .if_flush(if_flush),
        .redir_pending(redir_pending)
`ifdef PC_ALIGN_CHECK_EN
        , .bad_vaddr(bad_vaddr)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rst = 0; stall = 0; br_taken = 0; jmp = 0; jr = 0; eret = 0; exc = 0;
        br_target = 0; jmp_target = 0; jr_target = 0; epc = 0;
        pc = 32'h0040_0010; pc_4 = 32'h0040_0014;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; jr = 1; jr_target = 32'h1234_5678; exc = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks += 4;
            if (pc_next !== DEF) begin errors++; $display("FAIL reset_pc_next got=%h exp=%h", pc_next, DEF); end
            if (if_flush !== 1'b1) begin errors++; $display("FAIL reset_if_flush got=%b exp=1", if_flush); end
            if (redir_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", redir_pending); end
            if (pc_src !== 3'd0) begin errors++; $display("FAIL reset_pc_src got=%0d exp=0", pc_src); end
            next_cycle();
        end
        idle_inputs();
        pc = 32'h0040_0000; pc_4 = 32'h0040_0004;
        @(negedge clk);
        checks += 3;
        if (pc_next !== 32'h0040_0004) begin errors++; $display("FAIL post_reset_seq got=%h exp=00400004", pc_next); end
        if (if_flush !== 1'b0) begin errors++; $display("FAIL post_reset_flush got=%b exp=0", if_flush); end
        if (pc_src !== 3'd0) begin errors++; $display("FAIL post_reset_src got=%0d exp=0", pc_src); end
`ifdef PC_ALIGN_CHECK_EN
        checks++;
        if (bad_vaddr !== 32'h0) begin errors++; $display("FAIL reset_bad_vaddr got=%h exp=0", bad_vaddr); end
`endif
        next_cycle();
    endtask

    task automatic test_branch();
        logic exp_f;
        exp_f = (DS == 0);
        idle_inputs();
        br_taken = 1; br_target = 32'h0040_0100;
        @(negedge clk);
        checks += 3;
        if (pc_next !== 32'h0040_0100) begin errors++; $display("FAIL branch_pc got=%h exp=00400100", pc_next); end
        if (pc_src !== 3'd2) begin errors++; $display("FAIL branch_src got=%0d exp=2", pc_src); end
        if (if_flush !== exp_f) begin errors++; $display("FAIL branch_flush got=%b exp=%b", if_flush, exp_f); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks += 2;
        if (pc_next !== 32'h0040_0014) begin errors++; $display("FAIL branch_after got=%h exp=00400014", pc_next); end
        if (redir_pending !== 1'b0) begin errors++; $display("FAIL branch_after_pend got=%b exp=0", redir_pending); end
        next_cycle();
    endtask

    task automatic test_stall_redirect();
        idle_inputs();
        stall = 1; jmp = 1; jmp_target = 32'h0040_0200;
        @(negedge clk);
        checks += 3;
        if (pc_next !== 32'h0040_0010) begin errors++; $display("FAIL stall_latch_pc got=%h exp=00400010", pc_next); end
        if (pc_src !== 3'd1) begin errors++; $display("FAIL stall_latch_src got=%0d exp=1", pc_src); end
        if (redir_pending !== 1'b0) begin errors++; $display("FAIL stall_latch_pend got=%b exp=0", redir_pending); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            stall = 1;
            br_taken = (i == 1); br_target = 32'h0040_0600;
            @(negedge clk);
            checks += 2;
            if (pc_next !== 32'h0040_0010) begin errors++; $display("FAIL stall_hold_pc i=%0d got=%h exp=00400010", i, pc_next); end
            if (redir_pending !== 1'b1) begin errors++; $display("FAIL stall_hold_pend i=%0d got=%b exp=1", i, redir_pending); end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks += 3;
        if (pc_next !== 32'h0040_0200) begin errors++; $display("FAIL release_pc got=%h exp=00400200", pc_next); end
        if (pc_src !== 3'd7) begin errors++; $display("FAIL release_src got=%0d exp=7", pc_src); end
        if (if_flush !== (DS == 0)) begin errors++; $display("FAIL release_flush got=%b", if_flush); end
        next_cycle();
        @(negedge clk);
        checks += 2;
        if (pc_next !== 32'h0040_0014) begin errors++; $display("FAIL release_after got=%h exp=00400014", pc_next); end
        if (redir_pending !== 1'b0) begin errors++; $display("FAIL release_after_pend got=%b exp=0", redir_pending); end
        next_cycle();
    endtask

    task automatic test_priority();
        idle_inputs();
        exc = 1; jr = 1; jr_target = 32'h0040_0400; br_taken = 1; br_target = 32'h0040_0500;
        @(negedge clk);
        checks += 3;
        if (pc_next !== EXC) begin errors++; $display("FAIL prio_pc got=%h exp=%h", pc_next, EXC); end
        if (pc_src !== 3'd6) begin errors++; $display("FAIL prio_src got=%0d exp=6", pc_src); end
        if (if_flush !== 1'b1) begin errors++; $display("FAIL prio_flush got=%b exp=1", if_flush); end
        next_cycle();
        idle_inputs();
        br_taken = 1; br_target = 32'h0040_0500;
        @(negedge clk);
        checks += 3;
        if (pc_next !== 32'h0040_0014) begin errors++; $display("FAIL flush_pc got=%h exp=00400014", pc_next); end
        if (if_flush !== 1'b1) begin errors++; $display("FAIL flush_flag got=%b exp=1", if_flush); end
        if (pc_src !== 3'd0) begin errors++; $display("FAIL flush_src got=%0d exp=0", pc_src); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (if_flush !== 1'b0) begin errors++; $display("FAIL flush_one_cycle got=%b exp=0", if_flush); end
        next_cycle();
    endtask

    task automatic test_exc_in_pend();
        idle_inputs();
        stall = 1; br_taken = 1; br_target = 32'h0040_0300;
        next_cycle();
        idle_inputs();
        stall = 1;
        next_cycle();
        idle_inputs();
        stall = 1; exc = 1;
        @(negedge clk);
        checks += 2;
        if (pc_next !== EXC) begin errors++; $display("FAIL pend_exc_pc got=%h exp=%h", pc_next, EXC); end
        if (if_flush !== 1'b1) begin errors++; $display("FAIL pend_exc_flush got=%b exp=1", if_flush); end
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            stall = (i == 2);
            @(negedge clk);
            checks += 2;
            if (pc_next === 32'h0040_0300) begin errors++; $display("FAIL pend_discard i=%0d got=%h", i, pc_next); end
            if (redir_pending !== 1'b0) begin errors++; $display("FAIL pend_discard_flag i=%0d got=%b exp=0", i, redir_pending); end
            next_cycle();
        end
    endtask

`ifdef PC_ALIGN_CHECK_EN
    task automatic test_align();
        idle_inputs();
        jr = 1; jr_target = 32'h0040_0102;
        @(negedge clk);
        checks += 2;
        if (pc_next !== EXC) begin errors++; $display("FAIL align_pc got=%h exp=%h", pc_next, EXC); end
        if (if_flush !== 1'b1) begin errors++; $display("FAIL align_flush got=%b exp=1", if_flush); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bad_vaddr !== 32'h0040_0102) begin errors++; $display("FAIL align_bad_vaddr got=%h exp=00400102", bad_vaddr); end
        next_cycle();
    endtask
`endif

    task automatic model_redirect(input logic [31:0] t, input logic [2:0] s, input bit always_flush);
        if (ALIGN && t[1:0] != 2'b00) begin
            e_pc = EXC; e_src = 3'd6; e_flush = 1; n_flush = 1; n_bad = t;
        end else begin
            e_pc = t; e_src = s; e_flush = always_flush || (DS == 0); n_flush = always_flush;
        end
    endtask

    task automatic model_eval();
        logic [31:0] t;
        logic [2:0]  s;
        e_pend = m_pending && !rst;
        n_pending = m_pending; n_flush = 0; n_tgt = m_tgt; n_bad = m_bad;
        e_flush = 0; e_pc = pc_4; e_src = 3'd0;
        t = jr ? jr_target : (jmp ? jmp_target : br_target);
        s = jr ? 3'd4 : (jmp ? 3'd3 : 3'd2);
        if (rst) begin
            e_pc = DEF; e_flush = 1; n_pending = 0; n_tgt = 0; n_bad = 0;
        end else if (m_flush) begin
            e_flush = 1;
            if (exc) begin e_pc = EXC; e_src = 3'd6; n_flush = 1; end
            else if (stall) begin e_pc = pc; e_src = 3'd1; end
        end else if (exc) begin
            e_pc = EXC; e_src = 3'd6; e_flush = 1; n_flush = 1; n_pending = 0;
        end else if (eret) begin
            n_pending = 0;
            model_redirect(epc, 3'd5, 1'b1);
        end else if (m_pending) begin
            if (stall) begin e_pc = pc; e_src = 3'd1; end
            else begin n_pending = 0; model_redirect(m_tgt, 3'd7, 1'b0); end
        end else if (jr || jmp || br_taken) begin
            if (stall) begin e_pc = pc; e_src = 3'd1; n_pending = 1; n_tgt = t; end
            else model_redirect(t, s, 1'b0);
        end else if (stall) begin
            e_pc = pc; e_src = 3'd1;
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] v;
        v = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) v[1:0] = 2'($urandom_range(1, 3));
        return v;
    endfunction

    task automatic test_random();
        m_pending = 0; m_flush = 0; m_tgt = 0; m_bad = 0;
        for (int c = 0; c < 400; c++) begin
            rst        = (c == 0) || ($urandom_range(0, 63) == 0);
            stall      = ($urandom_range(0, 2) == 0);
            exc        = ($urandom_range(0, 15) == 0);
            eret       = ($urandom_range(0, 15) == 0);
            jr         = ($urandom_range(0, 5) == 0);
            jmp        = ($urandom_range(0, 5) == 0);
            br_taken   = ($urandom_range(0, 5) == 0);
            jr_target  = rand_target();
            jmp_target = rand_target();
            br_target  = rand_target();
            epc        = rand_target();
            pc         = $urandom & 32'hFFFF_FFFC;
            pc_4       = pc + 32'd4;
            @(negedge clk);
            model_eval();
            checks += 4;
            if (pc_next !== e_pc) begin errors++; $display("FAIL rnd_pc_next c=%0d got=%h exp=%h", c, pc_next, e_pc); end
            if (pc_src !== e_src) begin errors++; $display("FAIL rnd_pc_src c=%0d got=%0d exp=%0d", c, pc_src, e_src); end
            if (if_flush !== e_flush) begin errors++; $display("FAIL rnd_if_flush c=%0d got=%b exp=%b", c, if_flush, e_flush); end
            if (redir_pending !== e_pend) begin errors++; $display("FAIL rnd_pending c=%0d got=%b exp=%b", c, redir_pending, e_pend); end
`ifdef PC_ALIGN_CHECK_EN
            checks++;
            if (bad_vaddr !== m_bad) begin errors++; $display("FAIL rnd_bad_vaddr c=%0d got=%h exp=%h", c, bad_vaddr, m_bad); end
`endif
            @(posedge clk);
            m_pending = n_pending; m_flush = n_flush; m_tgt = n_tgt; m_bad = n_bad;
            #1;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_branch();
        test_stall_redirect();
        test_priority();
        test_exc_in_pend();
`ifdef PC_ALIGN_CHECK_EN
        test_align();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
